// File: rtl/pplsort_n.sv
// rtl/pplsort_n.sv - pipelined N-key odd-even transposition sorter with ready/valid flow control
// Optional key index tags under SORT_TAG_EN.
module pplsort_n #(
   parameter int WIDTH = 3,
   parameter int N     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_desc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WIDTH-1:0] out_data
`ifdef SORT_TAG_EN
   ,
   output logic [N*3-1:0]     out_tag
`endif
);

   logic               w_adv;
   logic [N*WIDTH-1:0] r_data [N];
   logic               r_desc [N-1];
   logic               r_valid [N];
   logic [N*WIDTH-1:0] w_din [N];
   logic [N*WIDTH-1:0] w_dout [N];
   logic               w_desc_in [N];
   logic               w_valid_in [N];
   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_b;
   logic               w_swap;
`ifdef SORT_TAG_EN
   logic [N*3-1:0]     r_tag [N];
   logic [N*3-1:0]     w_tin [N];
   logic [N*3-1:0]     w_tout [N];
   logic [2:0]         w_ta;
`endif

   // The whole pipeline moves as one; a stalled output freezes every stage.
   assign w_adv     = ~r_valid[N-1] | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_valid[N-1];
   assign out_data  = r_data[N-1];
`ifdef SORT_TAG_EN
   assign out_tag   = r_tag[N-1];
`endif

   always_comb begin
      w_din[0]      = in_data;
      w_desc_in[0]  = in_desc;
      w_valid_in[0] = in_valid;
`ifdef SORT_TAG_EN
      for (int k = 0; k < N; k++) w_tin[0][(N-k)*3-1 -: 3] = 3'(k);
`endif
      for (int s = 1; s < N; s++) begin
         w_din[s]      = r_data[s-1];
         w_desc_in[s]  = r_desc[s-1];
         w_valid_in[s] = r_valid[s-1];
`ifdef SORT_TAG_EN
         w_tin[s]      = r_tag[s-1];
`endif
      end
   end

   // Strict comparison keeps equal keys in place, which makes the network stable.
   always_comb begin
      w_a    = '0;
      w_b    = '0;
      w_swap = 1'b0;
`ifdef SORT_TAG_EN
      w_ta   = '0;
`endif
      for (int s = 0; s < N; s++) begin
         w_dout[s] = w_din[s];
`ifdef SORT_TAG_EN
         w_tout[s] = w_tin[s];
`endif
         for (int k = s % 2; k + 1 < N; k += 2) begin
            w_a    = w_din[s][(N-k)*WIDTH-1 -: WIDTH];
            w_b    = w_din[s][(N-k-1)*WIDTH-1 -: WIDTH];
            w_swap = w_desc_in[s] ? (w_a < w_b) : (w_a > w_b);
            if (w_swap) begin
               w_dout[s][(N-k)*WIDTH-1 -: WIDTH]   = w_b;
               w_dout[s][(N-k-1)*WIDTH-1 -: WIDTH] = w_a;
`ifdef SORT_TAG_EN
               w_ta                          = w_tin[s][(N-k)*3-1 -: 3];
               w_tout[s][(N-k)*3-1 -: 3]     = w_tin[s][(N-k-1)*3-1 -: 3];
               w_tout[s][(N-k-1)*3-1 -: 3]   = w_ta;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < N; s++) begin
            r_data[s]  <= '0;
            r_valid[s] <= 1'b0;
`ifdef SORT_TAG_EN
            r_tag[s]   <= '0;
`endif
         end
         for (int s = 0; s < N-1; s++) r_desc[s] <= 1'b0;
      end else if (w_adv) begin
         for (int s = 0; s < N; s++) begin
            r_data[s]  <= w_dout[s];
            r_valid[s] <= w_valid_in[s];
`ifdef SORT_TAG_EN
            r_tag[s]   <= w_tout[s];
`endif
         end
         for (int s = 0; s < N-1; s++) r_desc[s] <= w_desc_in[s];
      end
   end

endmodule
